// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;
  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2
  } feeder_state_e;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and full/empty flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at their width
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers producer bytes and paces them into the UART transmitter
// Optional level output enabled by UART_TX_FEEDER_LEVEL_EN.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [UART_BYTE_W-1:0] tx_data,
  output logic                   tx_req,
  input  logic                   tx_empty,
  output logic                   fifo_empty,
`ifdef UART_TX_FEEDER_LEVEL_EN
  output logic [PTR_W:0]         level,
`endif
  output logic                   overflow,
  input  logic                   ovf_clear
);
  feeder_state_e          state;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty_w;
  logic [PTR_W:0]         fifo_count;
  logic [UART_BYTE_W-1:0] head_data;

  assign wr_ready   = ~fifo_full;
  assign fifo_empty = fifo_empty_w;
  assign push       = wr_valid & ~fifo_full;
  assign pop        = (state == IDLE) && (fifo_count != '0) && tx_empty;

`ifdef UART_TX_FEEDER_LEVEL_EN
  assign level = fifo_count;
`endif

  sync_fifo #(
    .WIDTH (UART_BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty_w)
  );

  // The transmitter dropping tx_empty acknowledges the load; only then may we issue again
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_req  <= 1'b0;
      tx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= head_data;
            tx_req  <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          tx_req <= 1'b0;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_empty) state <= IDLE;
        end
        default: begin
          tx_req <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_valid && fifo_full) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - randomized self-checking bench against a queue-based reference model
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_empty = 1'b1;
  logic       fifo_empty;
  logic       overflow;
  logic       ovf_clear = 1'b0;
`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [4:0] level;
`endif

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .tx_data    (tx_data),
    .tx_req     (tx_req),
    .tx_empty   (tx_empty),
    .fifo_empty (fifo_empty),
`ifdef UART_TX_FEEDER_LEVEL_EN
    .level      (level),
`endif
    .overflow   (overflow),
    .ovf_clear  (ovf_clear)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // reference model: bytes buffered, issue gating, sticky overflow, last byte issued
  logic [7:0] q[$];
  int         phase = 0;
  bit         m_ovf = 1'b0;
  logic [7:0] last_data = 8'h00;
  int         rx_count = 0;

  // transmitter model
  bit force_busy = 1'b0;
  bit tx_pend = 1'b0;
  int tx_busy = 0;
  int cpb = 4;

  task automatic step();
    bit p_valid, p_txe, p_clr, p_rst, exp_req, acc;
    logic [7:0] p_data;
    p_valid = wr_valid; p_txe = tx_empty; p_clr = ovf_clear; p_rst = rst; p_data = wr_data;
    @(posedge clk);
    #1;
    if (p_rst) begin
      q.delete();
      phase = 0;
      m_ovf = 1'b0;
      last_data = 8'h00;
      check_eq("rst_tx_req", tx_req, 0);
      check_eq("rst_tx_data", tx_data, 0);
    end else begin
      exp_req = (phase == 0) && (q.size() > 0) && p_txe;
      acc = p_valid && (q.size() < DEPTH);
      check_eq("tx_req", tx_req, exp_req);
      if (exp_req) begin
        last_data = q.pop_front();
        rx_count++;
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2 && !p_txe) begin
        phase = 0;
      end
      check_eq("tx_data", tx_data, last_data);
      if (acc) q.push_back(p_data);
      if (p_valid && !acc) m_ovf = 1'b1;
      else if (p_clr) m_ovf = 1'b0;
    end
    check_eq("wr_ready", wr_ready, q.size() < DEPTH);
    check_eq("fifo_empty", fifo_empty, q.size() == 0);
    check_eq("overflow", overflow, m_ovf);
`ifdef UART_TX_FEEDER_LEVEL_EN
    check_eq("level", level, q.size());
`endif
    if (force_busy) tx_empty = 1'b0;
    else if (tx_req) begin tx_pend = 1'b1; tx_empty = 1'b1; end
    else if (tx_pend) begin tx_pend = 1'b0; tx_busy = cpb * 10 - 1; tx_empty = 1'b0; end
    else if (tx_busy > 0) begin tx_busy--; tx_empty = 1'b0; end
    else tx_empty = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    wr_valid = 1'b0;
    while ((q.size() > 0 || phase != 0 || tx_busy > 0 || tx_pend || !tx_empty) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_done", n < budget, 1);
  endtask

  initial begin
    int start, n, guard;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // single byte: request two cycles after the push
    cpb = 4;
    wr_valid = 1'b1; wr_data = 8'hA5;
    step();
    wr_valid = 1'b0;
    check_eq("single_n1_req", tx_req, 0);
    check_eq("single_n1_fifo_empty", fifo_empty, 0);
    step();
    check_eq("single_n2_req", tx_req, 1);
    check_eq("single_n2_data", tx_data, 8'hA5);
    step();
    check_eq("single_n3_req", tx_req, 0);
    drain(500);

    // back-to-back frames
    start = rx_count;
    for (int i = 1; i <= 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i);
      step();
    end
    drain(1000);
    check_eq("b2b_count", rx_count - start, 3);

    // fill and overflow while the transmitter is stalled
    force_busy = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h40 + i);
      step();
    end
    check_eq("fill_wr_ready", wr_ready, 0);
    wr_data = 8'hFF;
    step();
    wr_valid = 1'b0;
    check_eq("fill_overflow", overflow, 1);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    check_eq("ovf_cleared", overflow, 0);
    force_busy = 1'b0;
    drain(3000);

    // simultaneous push and pop at count 3
    force_busy = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h10 + i);
      step();
    end
    wr_valid = 1'b0;
    force_busy = 1'b0;
    step();
    wr_valid = 1'b1; wr_data = 8'h77;
    step();
    wr_valid = 1'b0;
    check_eq("pushpop_req", tx_req, 1);
    check_eq("pushpop_head", tx_data, 8'h10);
`ifdef UART_TX_FEEDER_LEVEL_EN
    check_eq("pushpop_level", level, 3);
`endif
    drain(1000);

    // reset while waiting for the transmitter with bytes buffered
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h60 + i);
      step();
    end
    wr_valid = 1'b0;
    guard = 0;
    while (!(phase == 2 && !tx_empty) && guard < 50) begin step(); guard++; end
    check_eq("mid_reached_wait", guard < 50, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_fifo_empty", fifo_empty, 1);
    check_eq("mid_tx_req", tx_req, 0);
    check_eq("mid_overflow", overflow, 0);
    start = rx_count;
    repeat (100) step();
    check_eq("mid_no_req", rx_count - start, 0);
    drain(500);

    // pointer wrap: 3*DEPTH sequential bytes with no loss
    cpb = 1;
    start = rx_count;
    n = 0;
    guard = 0;
    while (n < 3 * DEPTH && guard < 5000) begin
      bit rdy;
      rdy = (q.size() < DEPTH);
      wr_valid = 1'b1; wr_data = 8'(n);
      step();
      if (rdy) n++;
      guard++;
    end
    check_eq("wrap_pushed", n, 3 * DEPTH);
    drain(2000);
    check_eq("wrap_count", rx_count - start, 3 * DEPTH);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      wr_valid  = ($urandom_range(0, 2) == 0);
      wr_data   = 8'($urandom);
      ovf_clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) cpb = $urandom_range(1, 3);
      step();
    end
    ovf_clear = 1'b0;
    drain(5000);
    check_eq("final_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte-buffering front end for the UART transmitter. It accepts bytes from on-chip producers through a valid/ready handshake and stores them in a FIFO. It then hands them one at a time to the transmitter's `data`/`req` interface, issuing a request only while the transmitter reports `empty`. The block sits directly upstream of the transmitter, so producers never have to poll transmitter status or risk raising its `error` flag.

## Interface
Parameters:
- `DEPTH`, 16: FIFO capacity in bytes. Power of two, 2..256.
- `PTR_W`, $clog2(DEPTH): pointer width. Derived, not overridden.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_data`  in  8  byte from producer.
- `wr_valid`  in  1  producer offers `wr_data`.
- `wr_ready`  out  1  FIFO can accept; equals !full.
- `tx_data`  out  8  byte to transmitter; registered.
- `tx_req`  out  1  one-cycle load request to transmitter; registered.
- `tx_empty`  in  1  transmitter idle (transmitter `empty` output).
- `fifo_empty`  out  1  no bytes buffered.
- `overflow`  out  1  sticky: a write was attempted while full.
- `ovf_clear`  in  1  clears `overflow`.
- `level`  out  PTR_W+1  buffered byte count. Present only with UART_TX_FEEDER_LEVEL_EN.

## Operation
- **Push:** `wr_valid & wr_ready` writes `wr_data` at the write pointer, then the write pointer increments. Pointers wrap modulo DEPTH. A separate PTR_W+1 count distinguishes full from empty.
- **Rejected push:** `wr_valid & !wr_ready` drops the byte and sets `overflow`. `wr_ready` depends only on the count, never on the same-cycle pop.
- **Drain FSM states:** IDLE, SEND, WAIT_BUSY.
  - IDLE: if !fifo_empty & tx_empty, then tx_data <= head byte, pop, tx_req <= 1, go to SEND. Otherwise stay.
  - SEND: tx_req <= 0, go to WAIT_BUSY.
  - WAIT_BUSY: stay until tx_empty == 0, then go to IDLE. This is the acknowledge that the transmitter loaded the byte.
- **Simultaneous push and pop:** both occur. Count is unchanged, and both pointers advance.
- **Overflow flag:** `overflow` set has priority over `ovf_clear` in the same cycle.
- **Request discipline:** `tx_req` is never asserted unless `tx_empty` was 1 in the decision cycle. `tx_req` is never asserted twice without an intervening `tx_empty` low.

## Timing
- **Reset values:** wr_ready=1, tx_req=0, tx_data=8'h00, fifo_empty=1, overflow=0, level=0. FSM state = IDLE, pointers 0, count 0.
- **Mid-operation reset:** FIFO contents are discarded, and any in-flight request is abandoned. Resetting the transmitter is the system's responsibility.
- **Push latency:** a byte pushed in cycle N makes fifo_empty=0 in cycle N+1. The earliest decision is N+1, and tx_req=1 in N+2.
- **Request handshake:** tx_req high for exactly one cycle. tx_data is stable from the cycle tx_req rises until the next issue.
- **Transmitter acknowledge:** the transmitter drops `tx_empty` the cycle after tx_req. The FSM returns to IDLE one cycle later.
- **Back-to-back frames:** the next request issues the cycle after tx_empty returns high. Minimum spacing is the full frame plus two cycles.
- **Stuck transmitter:** if tx_empty never falls, the FSM waits in WAIT_BUSY indefinitely. There is no timeout.
- **Status timing:** fifo_empty and wr_ready are registered-count derived and reflect pushes/pops from the previous cycle.

## Configuration
- **UART_TX_FEEDER_LEVEL_EN defined:** the `level` port exists and equals the FIFO count.
- **UART_TX_FEEDER_LEVEL_EN undefined:** the port is absent, and the count stays internal. All other behaviour is identical.

## Structure
- **Package `uart_pkg`:** feeder state enum (IDLE=2'd0, SEND=2'd1, WAIT_BUSY=2'd2) and constant `UART_BYTE_W`=8.
- **Sub-module `sync_fifo`:** parameterised by width and depth. It owns the memory, pointers, count and full/empty. The feeder adds the drain FSM, registered outputs and overflow flag.

## Test plan
- **Single byte:** reset, then push 8'hA5 with tx_empty=1. tx_req pulses once, two cycles after the push, with tx_data=8'hA5. fifo_empty returns to 1.
- **Back-to-back:** push 8'h01, 8'h02, 8'h03 with a transmitter model (cycles_per_bit=4). Exactly three tx_req pulses in order. tx_req never asserts while tx_empty=0.
- **Fill and overflow:** with tx_empty=0, push DEPTH bytes, then one more (8'hFF). wr_ready=0 after DEPTH pushes, and overflow=1. 8'hFF is never transmitted. ovf_clear then clears overflow.
- **Push/pop same cycle:** at count 3, issue a pop and a push together. The count stays 3 (checked via level with UART_TX_FEEDER_LEVEL_EN), and byte order is preserved.
- **Reset mid-frame:** assert rst while in WAIT_BUSY with 5 bytes buffered. The next cycle shows fifo_empty=1, tx_req=0, overflow=0, and no further requests.
- **Pointer wrap:** transmit 3×DEPTH sequential bytes 8'h00 upward. The received sequence is exact, with no loss across wrap-around.
